// File: rtl/shift_rx8b.sv
// Serial-to-parallel receiver: LSB-first bit stream into WIDTH-bit words,
// with a one-deep output holding register, consumer handshake and sticky overrun.
module shift_rx8b #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_en,
  input  logic             s_in,
  input  logic             p_ack,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, word;
  logic             done, load, ovr_set;

  // Word being formed this edge; on completion it is the finished word.
  assign word = {s_in, sr[WIDTH-1:1]};
  assign done = s_en && !clr && (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (s_en) begin
      sr      <= word;
      bit_cnt <= done ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (done) state_nxt = FULL;
      FULL:  if (p_ack && !done) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // A completion is accepted when the holder is empty or drained on the same edge.
  always_comb begin
    p_valid = (state == FULL);
    load    = done && ((state == EMPTY) || p_ack);
    ovr_set = done && (state == FULL) && !p_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       p_out <= '0;
    else if (load) p_out <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun <= 1'b0;
    else if (clr)     overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
  end

endmodule
